// File: rtl/clock_pkg.sv
// Shared clock-datapath types, BCD limits and reset hours.
// Used by the hour counter and its digit registers.
package clock_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] hr_bin_t;

    localparam bcd_t    BCD_MAX      = 4'd9;
    localparam hr_bin_t HR12_MAX     = 8'd12;
    localparam hr_bin_t HR12_LAST    = 8'd11;
    localparam hr_bin_t HR24_MAX     = 8'd23;

    localparam bcd_t    TENS12_MAX   = 4'd1;
    localparam bcd_t    TENS24_MAX   = 4'd2;
    localparam bcd_t    UNITS24_TOP  = 4'd3;
    localparam bcd_t    UNITS12_WRAP = 4'd1;

    localparam bcd_t    RST12_TENS   = 4'd1;
    localparam bcd_t    RST12_UNITS  = 4'd2;
    localparam bcd_t    RST24_TENS   = 4'd0;
    localparam bcd_t    RST24_UNITS  = 4'd0;

    function automatic hr_bin_t bcd_to_bin(bcd_t t, bcd_t u);
        return hr_bin_t'(t) * 8'd10 + hr_bin_t'(u);
    endfunction

    function automatic logic hour_valid(logic mode24, bcd_t t, bcd_t u);
        hr_bin_t v;
        v = bcd_to_bin(t, u);
        if (u > BCD_MAX) return 1'b0;
        if (mode24) return v <= HR24_MAX;
        return (v != 8'd0) && (v <= HR12_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: load has priority, inc counts up and
// wraps to zero after reaching wrap_i, flagging a carry.
module bcd_digit
    import clock_pkg::*;
#(
    parameter bcd_t RST_VAL = 4'd0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic inc_i,
    input  bcd_t wrap_i,
    output bcd_t q_o,
    output logic carry_o
);

    bcd_t q_q;
    bcd_t q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (inc_i) begin
            q_d = (q_q == wrap_i) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) q_q <= RST_VAL;
        else          q_q <= q_d;
    end

    assign q_o     = q_q;
    assign carry_o = inc_i && !load_i && (q_q == wrap_i);

endmodule

// File: rtl/hour_counter.sv
// BCD hour counter, 12h (with PM flag) or 24h, with validated load
// and one-cycle day_tick / set_err pulses.
module hour_counter
    import clock_pkg::*;
#(
    parameter bit MODE_24H = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic set,
    input  bcd_t new_tens,
    input  bcd_t new_units,
    input  logic new_pm,
    output bcd_t hr_tens,
    output bcd_t hr_units,
    output logic pm,
    output logic day_tick,
    output logic set_err
);

    localparam bcd_t RST_TENS  = MODE_24H ? RST24_TENS  : RST12_TENS;
    localparam bcd_t RST_UNITS = MODE_24H ? RST24_UNITS : RST12_UNITS;
    localparam bcd_t TENS_WRAP = MODE_24H ? TENS24_MAX  : TENS12_MAX;

    bcd_t    tens_q, units_q;
    logic    pm_q, pm_d;
    logic    tick_q, tick_d;
    logic    err_q, err_d;

    logic    u_ld, t_ld, u_inc;
    bcd_t    u_val, t_val, u_wrap;
    logic    u_carry, t_carry;
    logic    valid, load_ok, adv;
    hr_bin_t hr_bin, ld_bin;

    assign hr_bin  = bcd_to_bin(tens_q, units_q);
    assign ld_bin  = bcd_to_bin(new_tens, new_units);
    assign valid   = hour_valid(MODE_24H, new_tens, new_units);
    assign load_ok = set && valid;
    assign adv     = inc && !set;
    assign err_d   = set && !valid;

    // 20..23 wrap the units digit at 3 instead of 9
    assign u_wrap = (MODE_24H && tens_q == TENS24_MAX) ? UNITS24_TOP
                                                       : BCD_MAX;

    always_comb begin
        u_ld   = 1'b0;
        u_val  = 4'd0;
        t_ld   = 1'b0;
        t_val  = 4'd0;
        u_inc  = 1'b0;
        pm_d   = pm_q;
        tick_d = 1'b0;
        unique case (1'b1)
            load_ok: begin
                u_ld  = 1'b1;
                u_val = new_units;
                t_ld  = 1'b1;
                t_val = new_tens;
                pm_d  = MODE_24H ? (ld_bin >= HR12_MAX) : new_pm;
            end
            adv: begin
                if (MODE_24H) begin
                    u_inc  = 1'b1;
                    pm_d   = (hr_bin >= HR12_LAST) && (hr_bin < HR24_MAX);
                    tick_d = t_carry;
                end else begin
                    // 12 -> 01 is not a plain carry, so it is a forced load
                    if (hr_bin == HR12_MAX) begin
                        u_ld  = 1'b1;
                        u_val = UNITS12_WRAP;
                        t_ld  = 1'b1;
                        t_val = 4'd0;
                    end else begin
                        u_inc = 1'b1;
                    end
                    if (hr_bin == HR12_LAST) pm_d = ~pm_q;
                    tick_d = (hr_bin == HR12_LAST) && pm_q;
                end
            end
            default: ;
        endcase
    end

    bcd_digit #(.RST_VAL(RST_UNITS)) u_units (
        .clk_i      (clk),
        .rst_n_i    (reset_n),
        .load_i     (u_ld),
        .load_val_i (u_val),
        .inc_i      (u_inc),
        .wrap_i     (u_wrap),
        .q_o        (units_q),
        .carry_o    (u_carry)
    );

    bcd_digit #(.RST_VAL(RST_TENS)) u_tens (
        .clk_i      (clk),
        .rst_n_i    (reset_n),
        .load_i     (t_ld),
        .load_val_i (t_val),
        .inc_i      (u_carry),
        .wrap_i     (TENS_WRAP),
        .q_o        (tens_q),
        .carry_o    (t_carry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pm_q   <= 1'b0;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pm_q   <= pm_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    assign hr_tens  = tens_q;
    assign hr_units = units_q;
    assign pm       = pm_q;
    assign day_tick = tick_q;
    assign set_err  = err_q;

endmodule

// File: tb/tb_hour_counter.sv
// Bench for hour_counter: 12h and 24h instances share stimulus and
// are checked every cycle against an hour-of-day model.
module tb_hour_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       inc, set, new_pm;
    logic [3:0] new_tens, new_units;

    logic [3:0] t12, u12, t24, u24;
    logic       pm12, dt12, se12, pm24, dt24, se24;

    int checks = 0;
    int errors = 0;

    // model: hour of day 0..23 for each instance
    int m12, m24;
    bit tick12, tick24, err12, err24;

    always #5 clk = ~clk;

    hour_counter #(.MODE_24H(1'b0)) dut12 (
        .clk(clk), .reset_n(reset_n), .inc(inc), .set(set),
        .new_tens(new_tens), .new_units(new_units), .new_pm(new_pm),
        .hr_tens(t12), .hr_units(u12), .pm(pm12),
        .day_tick(dt12), .set_err(se12)
    );

    hour_counter #(.MODE_24H(1'b1)) dut24 (
        .clk(clk), .reset_n(reset_n), .inc(inc), .set(set),
        .new_tens(new_tens), .new_units(new_units), .new_pm(new_pm),
        .hr_tens(t24), .hr_units(u24), .pm(pm24),
        .day_tick(dt24), .set_err(se24)
    );

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic int disp12(int h);
        int x;
        x = h % 12;
        return (x == 0) ? 12 : x;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int v;
        if (!reset_n) begin
            m12 = 0; m24 = 0;
            tick12 = 0; tick24 = 0; err12 = 0; err24 = 0;
        end else begin
            tick12 = 0; tick24 = 0; err12 = 0; err24 = 0;
            v = int'(new_tens) * 10 + int'(new_units);
            if (set) begin
                if (new_units <= 9 && v >= 1 && v <= 12)
                    m12 = (v % 12) + (new_pm ? 12 : 0);
                else
                    err12 = 1;
                if (new_units <= 9 && v <= 23) m24 = v;
                else                            err24 = 1;
            end else if (inc) begin
                tick12 = (m12 == 23);
                tick24 = (m24 == 23);
                m12 = (m12 + 1) % 24;
                m24 = (m24 + 1) % 24;
            end
        end
    end

    always @(negedge clk) begin
        chk("h12_tens",  t12,  disp12(m12) / 10);
        chk("h12_units", u12,  disp12(m12) % 10);
        chk("h12_pm",    pm12, int'(m12 >= 12));
        chk("h12_tick",  dt12, int'(tick12));
        chk("h12_err",   se12, int'(err12));
        chk("h24_tens",  t24,  m24 / 10);
        chk("h24_units", u24,  m24 % 10);
        chk("h24_pm",    pm24, int'(m24 >= 12));
        chk("h24_tick",  dt24, int'(tick24));
        chk("h24_err",   se24, int'(err24));
    end

    task automatic step(input logic i, input logic s,
                        input logic [3:0] t, input logic [3:0] u,
                        input logic p);
        @(negedge clk);
        inc = i; set = s; new_tens = t; new_units = u; new_pm = p;
        @(posedge clk);
        #1;
        inc = 1'b0; set = 1'b0;
    endtask

    task automatic lit12(string nm, int t, int u, int p);
        chk({nm, "_t12"}, t12, t);
        chk({nm, "_u12"}, u12, u);
        chk({nm, "_pm12"}, pm12, p);
    endtask

    task automatic lit24(string nm, int t, int u, int p);
        chk({nm, "_t24"}, t24, t);
        chk({nm, "_u24"}, u24, u);
        chk({nm, "_pm24"}, pm24, p);
    endtask

    initial begin
        reset_n = 1'b0;
        inc = 0; set = 0; new_tens = 0; new_units = 0; new_pm = 0;
        #12;
        lit12("rst", 1, 2, 0);
        lit24("rst", 0, 0, 0);
        chk("rst_dt12", dt12, 0);
        chk("rst_se24", se24, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0, 0, 0);
            if (i == 11) lit12("p11", 1, 1, 0);
            step(0, 0, 0, 0, 0);
        end
        lit12("p12", 1, 2, 1);
        lit24("p12", 1, 2, 1);

        step(0, 1, 1, 1, 1);
        lit12("ld11", 1, 1, 1);
        lit24("ld11", 1, 1, 0);
        step(1, 0, 0, 0, 0);
        lit12("wrap12", 1, 2, 0);
        chk("wrap12_dt", dt12, 1);
        lit24("to12", 1, 2, 1);
        chk("to12_dt24", dt24, 0);
        step(0, 0, 0, 0, 0);
        chk("wrap12_dt_end", dt12, 0);

        step(0, 1, 2, 3, 0);
        chk("ld23_se12", se12, 1);
        lit12("ld23_hold", 1, 2, 0);
        lit24("ld23", 2, 3, 1);
        step(1, 0, 0, 0, 0);
        chk("inc_se12_end", se12, 0);
        lit24("wrap24", 0, 0, 0);
        chk("wrap24_dt", dt24, 1);
        lit12("to01", 0, 1, 0);

        step(0, 1, 1, 9, 0);
        chk("ld19_se12", se12, 1);
        lit24("ld19", 1, 9, 1);
        step(1, 0, 0, 0, 0);
        lit24("to20", 2, 0, 1);

        step(0, 1, 2, 4, 0);
        chk("ld24_se24", se24, 1);
        lit24("ld24_hold", 2, 0, 1);
        step(0, 1, 1, 3, 1);
        chk("ld13_se12", se12, 1);
        lit24("ld13", 1, 3, 1);

        step(1, 1, 0, 5, 0);
        lit12("setinc", 0, 5, 0);
        lit24("setinc", 0, 5, 0);
        chk("setinc_dt12", dt12, 0);
        chk("setinc_dt24", dt24, 0);

        @(negedge clk);
        inc = 1'b1;
        repeat (30) @(negedge clk);
        inc = 1'b0;

        for (int t = 0; t < 4; t++) begin
            for (int u = 0; u < 16; u++) begin
                logic [3:0] uu;
                uu = 4'(u);
                step(0, 1, 4'(t), uu, uu[0]);
                step(1, 0, 0, 0, 0);
            end
        end

        step(0, 1, 1, 0, 1);
        @(negedge clk);
        inc = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        lit12("arst", 1, 2, 0);
        lit24("arst", 0, 0, 0);
        @(negedge clk);
        inc = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0);
        lit12("post_rst", 1, 2, 0);
        lit24("post_rst", 0, 0, 0);
        step(1, 0, 0, 0, 0);
        lit12("resume", 0, 1, 0);
        lit24("resume", 0, 1, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
